// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and GF(2^8) transforms used by the inverse cipher datapath.
package aes_pkg;

    // state[c][r] holds FIPS byte 4*(3-c)+(3-r); byte 0 sits in the top 8 bits.
    typedef logic [3:0][3:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } aes_fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:3][7:0] INV_MIX_ROW = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Row r is rotated right by r positions, so byte (r,c) comes from column (c - r) mod 4.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[2'(3 - c)][2'(3 - r)] = s[2'(3 - ((c + 4 - r) % 4))][2'(3 - r)];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[2'(c)][2'(r)] = INV_SBOX[s[2'(c)][2'(r)]];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] acc;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                acc = '0;
                for (int unsigned k = 0; k < 4; k++) begin
                    acc ^= gmul(INV_MIX_ROW[2'((k + 4 - r) % 4)], s[2'(3 - c)][2'(3 - k)]);
                end
                o[2'(3 - c)][2'(3 - r)] = acc;
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last=1 omits InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t   state,
    input  logic [127:0] rkey,
    input  logic         last,
    output aes_state_t   result
);

    aes_state_t keyed;

    always_comb begin
        keyed  = aes_state_t'(inv_sub_bytes(inv_shift_rows(state)) ^ rkey);
        result = last ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher with valid/ready handshakes on both sides.
// Define AES_INV_UNROLL2_EN to process two rounds per clock.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter  int Nk = 4,
    localparam int Nr = Nk + 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] k_sch [0:Nr],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    localparam int CW = $clog2(Nr + 1);

    aes_fsm_t      fsm_q, fsm_d;
    aes_state_t    state_q, state_d;
    aes_state_t    round_out;
    logic [CW-1:0] rnd_q, rnd_d;
    logic [127:0]  pt_d;
    logic          out_valid_d;
    logic          in_ready_d;
    logic          last_step;

`ifdef AES_INV_UNROLL2_EN
    localparam logic [CW-1:0] STEP   = CW'(2);
    localparam logic [CW-1:0] LAST_R = CW'(1);

    aes_state_t    mid;
    logic [CW-1:0] rnd_lo;

    // Counter walks odd values Nr-1..1; the guard only matters in IDLE where the result is unused.
    assign rnd_lo = (rnd_q == '0) ? '0 : rnd_q - CW'(1);

    aes_inv_round u_round_hi (
        .state  (state_q),
        .rkey   (k_sch[rnd_q]),
        .last   (1'b0),
        .result (mid)
    );

    aes_inv_round u_round_lo (
        .state  (mid),
        .rkey   (k_sch[rnd_lo]),
        .last   (last_step),
        .result (round_out)
    );
`else
    localparam logic [CW-1:0] STEP   = CW'(1);
    localparam logic [CW-1:0] LAST_R = CW'(0);

    aes_inv_round u_round (
        .state  (state_q),
        .rkey   (k_sch[rnd_q]),
        .last   (last_step),
        .result (round_out)
    );
`endif

    assign last_step = (rnd_q == LAST_R);

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        pt_d        = pt;
        out_valid_d = out_valid;

        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = aes_state_t'(ct ^ k_sch[Nr]);
                    rnd_d   = CW'(Nr - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (last_step) begin
                    pt_d        = round_out;
                    out_valid_d = 1'b1;
                    fsm_d       = ST_DONE;
                end else begin
                    state_d = round_out;
                    rnd_d   = rnd_q - STEP;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        in_ready_d = (fsm_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= ST_IDLE;
            state_q   <= '0;
            rnd_q     <= '0;
            pt        <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            pt        <= pt_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: known answers plus random blocks encrypted by a forward-cipher model.
module tb_aes_inv_cipher;

`ifdef AES_INV_UNROLL2_EN
    localparam bit UNROLL = 1'b1;
`else
    localparam bit UNROLL = 1'b0;
`endif

    typedef logic [127:0] sched_t [0:14];

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY3    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready;
    logic [127:0] ct [3];
    logic [127:0] pt [3];
    logic [127:0] ks4 [0:10];
    logic [127:0] ks6 [0:12];
    logic [127:0] ks8 [0:14];
    logic [7:0]   sbox_m [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_inv_cipher #(.Nk(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks4),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ct(ct[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .pt(pt[0])
    );

    aes_inv_cipher #(.Nk(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks6),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ct(ct[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .pt(pt[1])
    );

    aes_inv_cipher #(.Nk(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks8),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .ct(ct[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .pt(pt[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0]  inv;
        logic [15:0] d;
        logic [7:0]  s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ 8'h63;
            for (int n = 1; n <= 4; n++) begin
                d = {inv, inv} << n;
                s ^= d[15:8];
            end
            sbox_m[a] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic void expand(input logic [255:0] key, input int nk, output sched_t rk);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int k = 0; k < 15; k++)
            rk[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input sched_t rk, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = p ^ rk[0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_m[v[127 - 8*b -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = (rd == nr) ? t[r + 4*c] :
                                 gf_mul(8'h02, t[r + 4*c]) ^ gf_mul(8'h03, t[(r+1)%4 + 4*c]) ^
                                 t[(r+2)%4 + 4*c] ^ t[(r+3)%4 + 4*c];
            for (int b = 0; b < 16; b++) v[127 - 8*b -: 8] = s[b];
            v ^= rk[rd];
        end
        return v;
    endfunction

    function automatic int latency(input int nr);
        return UNROLL ? nr/2 + 1 : nr + 1;
    endfunction

    task automatic load_sched(input int idx, input sched_t rk);
        case (idx)
            0:       for (int k = 0; k <= 10; k++) ks4[k] = rk[k];
            1:       for (int k = 0; k <= 12; k++) ks6[k] = rk[k];
            default: for (int k = 0; k <= 14; k++) ks8[k] = rk[k];
        endcase
    endtask

    // Called at a negedge; offers one block, checks latency and result, completes the handshake.
    task automatic run_block(input int idx, input logic [127:0] c, input logic [127:0] exp, input string tag);
        int n;
        int nr;
        nr = 10 + 2*idx;
        n  = 0;
        while (!in_ready[idx] && n < 200) begin @(negedge clk); n++; end
        check({tag, "_rdy"}, 128'(in_ready[idx]), 128'd1);
        in_valid[idx] = 1'b1;
        ct[idx]       = c;
        @(negedge clk);
        in_valid[idx] = 1'b0;
        ct[idx]       = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = 1;
        while (!out_valid[idx] && n < 200) begin @(negedge clk); n++; end
        check({tag, "_lat"}, 128'(n), 128'(latency(nr)));
        check({tag, "_pt"}, pt[idx], exp);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check({tag, "_hs"}, 128'({out_valid[idx], in_ready[idx]}), 128'(2'b01));
    endtask

    initial begin
        sched_t       s1, s3, s6, s8, sr;
        logic [255:0] key;
        logic [127:0] p;
        int           n, cyc, nacc, nout;
        int           acc_cyc [2];
        bit           acc_now;

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) ct[i] = '0;
        build_sbox();
        expand({KEY_SEQ[255:128], 128'h0}, 4, s1);
        expand(KEY3, 4, s3);
        expand({KEY_SEQ[255:64], 64'h0}, 6, s6);
        expand(KEY_SEQ, 8, s8);
        load_sched(0, s1);
        load_sched(1, s6);
        load_sched(2, s8);

        repeat (2) @(negedge clk);
        check("rst_flags", 128'({in_ready, out_valid}), 128'(6'b111_000));
        check("rst_pt", pt[0], 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block(0, CT1, PT1, "kat128");
        run_block(1, CT6, PT1, "kat192");
        run_block(2, CT8, PT1, "kat256");
        load_sched(0, s3);
        run_block(0, CT3, PT3, "kat_fips");

        for (int idx = 0; idx < 3; idx++) begin
            for (int it = 0; it < 3; it++) begin
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                p   = {$urandom(), $urandom(), $urandom(), $urandom()};
                expand(key, 4 + 2*idx, sr);
                load_sched(idx, sr);
                run_block(idx, encrypt(p, sr, 10 + 2*idx), p, "rand");
            end
        end

        // Backpressure: result must hold while out_ready stays low.
        load_sched(0, s1);
        in_valid[0] = 1'b1;
        ct[0]       = CT1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 20; i++) begin
            check("bp_pt", pt[0], PT1);
            check("bp_flags", 128'({out_valid[0], in_ready[0]}), 128'(2'b10));
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_release", 128'({out_valid[0], in_ready[0]}), 128'(2'b01));

        // Back-to-back with in_valid held high and out_ready permanently asserted.
        load_sched(0, s1);
        in_valid[0]  = 1'b1;
        ct[0]        = CT1;
        out_ready[0] = 1'b1;
        nacc = 0;
        nout = 0;
        cyc  = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        while (nout < 2 && cyc < 200) begin
            acc_now = in_valid[0] && in_ready[0];
            if (out_valid[0]) begin
                check("b2b_pt", pt[0], (nout == 0) ? PT1 : PT3);
                check("b2b_no_acc_done", 128'(in_ready[0]), 128'd0);
                if (nout == 0) load_sched(0, s3);
                nout++;
            end
            @(negedge clk);
            cyc++;
            if (acc_now && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                ct[0] = (nacc == 1) ? CT3 : {$urandom(), $urandom(), $urandom(), $urandom()};
                if (nacc == 2) in_valid[0] = 1'b0;
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check("b2b_outputs", 128'(nout), 128'd2);
        check("b2b_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'(latency(10) + 1));
        @(negedge clk);

        // Asynchronous reset in the middle of a decryption.
        in_valid[0] = 1'b1;
        ct[0]       = CT3;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 128'({in_ready[0], out_valid[0]}), 128'(2'b10));
        check("mid_rst_pt", pt[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(0, CT3, PT3, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
